// File: rtl/mcu_clk_pkg.sv
// Shared encodings and helpers for the 8051 machine-cycle clock scheduler.
// Modes, state numbering and the ALE phase decode live here.
package mcu_clk_pkg;

    localparam int MC_PHASES = 12;
    localparam int DIV_W     = 4;

    localparam logic [DIV_W-1:0] DIV_ONE = 4'd1;

    typedef enum logic [1:0] {
        MODE_RUN  = 2'd0,
        MODE_IDLE = 2'd1,
        MODE_PD   = 2'd2
    } mode_e;

    localparam logic [2:0] S1 = 3'd1;
    localparam logic [2:0] S2 = 3'd2;
    localparam logic [2:0] S3 = 3'd3;
    localparam logic [2:0] S4 = 3'd4;
    localparam logic [2:0] S5 = 3'd5;
    localparam logic [2:0] S6 = 3'd6;

    // ALE is high in S1P2, S2P1, S4P2, S5P1 in RUN; forced high in IDLE, low in PD.
    function automatic logic ale_decode(input logic [2:0] st, input logic ph2, input mode_e md);
        logic run_ale;
        case (st)
            S1, S4:  run_ale = ph2;
            S2, S5:  run_ale = ~ph2;
            S3, S6:  run_ale = 1'b0;
            default: run_ale = 1'b0;
        endcase
        case (md)
            MODE_RUN:  return run_ale;
            MODE_IDLE: return 1'b1;
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Phase prescaler: counts clk_in cycles up to the active ratio and emits a tick.
// A new ratio waits in a pending register until the tick that enters S1P1.
module tick_gen
    import mcu_clk_pkg::*;
#(
    parameter logic [DIV_W-1:0] DIV_RST = 4'd1
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             freeze,
    input  logic             load,
    input  logic             div_wr,
    input  logic [DIV_W-1:0] div_val,
    output logic             tick,
    output logic             at_boundary
);

    logic [DIV_W-1:0] cnt_r;
    logic [DIV_W-1:0] div_r;
    logic [DIV_W-1:0] pend_r;
    logic [DIV_W-1:0] div_val_s;

    assign div_val_s   = (div_val == 4'd0) ? DIV_ONE : div_val;
    assign tick        = ~freeze && (cnt_r == (div_r - DIV_ONE));
    assign at_boundary = tick && load;

    // Prescaler counter, pending ratio capture and ratio swap at the machine-cycle boundary.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r  <= 4'd0;
            div_r  <= DIV_RST;
            pend_r <= DIV_RST;
        end else begin
            if (freeze || tick) begin
                cnt_r <= 4'd0;
            end else begin
                cnt_r <= cnt_r + DIV_ONE;
            end
            if (div_wr) begin
                pend_r <= div_val_s;
            end
            if (at_boundary) begin
                div_r <= pend_r;
            end
        end
    end

endmodule

// File: rtl/mcycle_sched.sv
// 8051 machine-cycle scheduler: S1P1..S6P2 sequencer, PCON run/idle/power-down
// mode FSM, registered phase enables and ALE decode, all on clk_in.
module mcycle_sched
    import mcu_clk_pkg::*;
#(
    parameter logic [DIV_W-1:0] DIV_RST = 4'd1
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             div_wr,
    input  logic [DIV_W-1:0] div_val,
    input  logic             idle_req,
    input  logic             pd_req,
    input  logic             wake,
    output logic             periph_en,
    output logic             cpu_en,
    output logic             mc_start,
    output logic [2:0]       state,
    output logic             p2,
    output logic             ale,
    output logic [1:0]       mode
);

    localparam logic [3:0] LAST_PHASE = 4'(MC_PHASES - 1);

    // Phase index 0..11: state = index/2 + 1, p2 = index LSB.
    logic [3:0] phase_r;
    logic [3:0] phase_nxt_s;
    mode_e      mode_r;
    mode_e      mode_nxt_s;
    logic       idle_pend_r;
    logic       pd_pend_r;
    logic       wake_pend_r;
    logic       idle_s;
    logic       pd_s;
    logic       wake_s;
    logic       tick_s;
    logic       bnd_s;
    logic       last_s;
    logic       freeze_s;
    logic       periph_en_r;
    logic       cpu_en_r;
    logic       mc_start_r;

    assign last_s   = (phase_r == LAST_PHASE);
    assign freeze_s = (mode_r == MODE_PD);

    tick_gen #(
        .DIV_RST (DIV_RST)
    ) u_tick_gen (
        .clk_in      (clk_in),
        .rst_n       (rst_n),
        .freeze      (freeze_s),
        .load        (last_s),
        .div_wr      (div_wr),
        .div_val     (div_val),
        .tick        (tick_s),
        .at_boundary (bnd_s)
    );

    // Next phase and next mode; a request arriving on the boundary cycle itself is honoured.
    always_comb begin
        idle_s      = idle_pend_r | idle_req;
        pd_s        = pd_pend_r | pd_req;
        wake_s      = wake_pend_r | wake;
        phase_nxt_s = phase_r;
        mode_nxt_s  = mode_r;
        if (tick_s) begin
            if (last_s) begin
                phase_nxt_s = 4'd0;
            end else begin
                phase_nxt_s = phase_r + 4'd1;
            end
        end else begin
            phase_nxt_s = phase_r;
        end
        if (bnd_s) begin
            case (mode_r)
                MODE_RUN: begin
                    if (pd_s) begin
                        mode_nxt_s = MODE_PD;
                    end else if (idle_s) begin
                        mode_nxt_s = MODE_IDLE;
                    end else begin
                        mode_nxt_s = MODE_RUN;
                    end
                end
                MODE_IDLE: begin
                    if (pd_s) begin
                        mode_nxt_s = MODE_PD;
                    end else if (wake_s) begin
                        mode_nxt_s = MODE_RUN;
                    end else begin
                        mode_nxt_s = MODE_IDLE;
                    end
                end
                default: mode_nxt_s = mode_r;
            endcase
        end else begin
            mode_nxt_s = mode_r;
        end
    end

    // Sequencer, mode and enable registers.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            phase_r     <= LAST_PHASE;
            mode_r      <= MODE_RUN;
            periph_en_r <= 1'b0;
            cpu_en_r    <= 1'b0;
            mc_start_r  <= 1'b0;
        end else begin
            phase_r     <= phase_nxt_s;
            mode_r      <= mode_nxt_s;
            periph_en_r <= tick_s && (mode_nxt_s != MODE_PD);
            cpu_en_r    <= tick_s && (mode_nxt_s == MODE_RUN);
            mc_start_r  <= bnd_s && (mode_nxt_s == MODE_RUN);
        end
    end

    // Pending PCON requests; every boundary consumes whatever was pending.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            idle_pend_r <= 1'b0;
            pd_pend_r   <= 1'b0;
            wake_pend_r <= 1'b0;
        end else if (bnd_s) begin
            idle_pend_r <= 1'b0;
            pd_pend_r   <= 1'b0;
            wake_pend_r <= 1'b0;
        end else begin
            idle_pend_r <= idle_pend_r | (idle_req && (mode_r == MODE_RUN));
            pd_pend_r   <= pd_pend_r | (pd_req && (mode_r != MODE_PD));
            wake_pend_r <= wake_pend_r | (wake && (mode_r == MODE_IDLE));
        end
    end

    assign state     = phase_r[3:1] + 3'd1;
    assign p2        = phase_r[0];
    assign mode      = mode_r;
    assign ale       = ale_decode(state, p2, mode_r);
    assign periph_en = periph_en_r;
    assign cpu_en    = cpu_en_r;
    assign mc_start  = mc_start_r;

endmodule
